// File: rtl/arilla_bus_arbiter_pkg.sv
// Shared types and helpers for the arilla bus arbiter.
// Holds the FSM state encoding, owner-index width helper and round-robin pointer step.
// No logic of its own; imported by the arbiter top and its selector.
package arilla_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_e;

    // A single manager still needs a one-bit index.
    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int next_rr_index(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/arilla_rr_select.sv
// Request selector: first requester at or after ptr (round-robin) or lowest index (fixed).
// Latency: purely combinational.
// Backpressure: none; the caller decides when the winner is consumed.
module arilla_rr_select
    import arilla_bus_arbiter_pkg::*;
#(
    parameter int N    = 2,
    parameter int IdxW = 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    input  logic            rr_mode,
    output logic [N-1:0]    win_onehot,
    output logic [IdxW-1:0] win_idx,
    output logic            win_vld
);

    int              cand;
    logic [IdxW-1:0] sel;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_vld    = 1'b0;
        cand       = 0;
        sel        = '0;
        for (int k = 0; k < N; k++) begin
            cand = rr_mode ? int'(ptr) + k : k;
            if (cand >= N) begin
                cand = cand - N;
            end
            sel = IdxW'(cand);
            if (!win_vld && req[sel]) begin
                win_vld         = 1'b1;
                win_onehot[sel] = 1'b1;
                win_idx         = sel;
            end
        end
    end

endmodule

// File: rtl/arilla_bus_arbiter.sv
// Multi-manager arbiter for the arilla bus; one transaction in flight, optional watchdog via ARILLA_BUS_ARBITER_TIMEOUT_EN.
// Latency: write grant 1 cycle after m_req; read response 1 cycle after s_rvalid; one IDLE bubble between transactions.
// Backpressure: s_ready low holds the latched request on s_* indefinitely; m_gnt only fires on acceptance.
module arilla_bus_arbiter
    import arilla_bus_arbiter_pkg::*;
#(
    parameter int NumManagers      = 2,
    parameter int DataWidth        = 32,
    parameter int ByteAddressWidth = 32,
    parameter int ByteSize         = 8,
    parameter int RoundRobin       = 1,
    parameter int TimeoutCycles    = 256
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic [NumManagers-1:0]                             m_req,
    input  logic [NumManagers-1:0]                             m_we,
    input  logic [NumManagers-1:0][ByteAddressWidth-1:0]       m_addr,
    input  logic [NumManagers-1:0][DataWidth-1:0]              m_wdata,
    input  logic [NumManagers-1:0][DataWidth/ByteSize-1:0]     m_be,
    output logic [NumManagers-1:0]                             m_gnt,
    output logic [NumManagers-1:0]                             m_rvalid,
    output logic [DataWidth-1:0]                               m_rdata,
    output logic                                               m_rerr,
    output logic                                               s_req,
    output logic                                               s_we,
    output logic [ByteAddressWidth-1:0]                        s_addr,
    output logic [DataWidth-1:0]                               s_wdata,
    output logic [DataWidth/ByteSize-1:0]                      s_be,
    input  logic                                               s_ready,
    input  logic                                               s_rvalid,
    input  logic [DataWidth-1:0]                               s_rdata
);

    localparam int OwnerW = owner_width(NumManagers);
    localparam int BeW    = DataWidth / ByteSize;

    state_e                state_q, state_d;
    logic [OwnerW-1:0]     owner_q, ptr_q, win_idx;
    logic [NumManagers-1:0] win_onehot;
    logic                  win_vld;
    logic                  accept, resp_fire, rvalid_q;
    logic                  sel_we;
    logic [ByteAddressWidth-1:0] sel_addr;
    logic [DataWidth-1:0]  sel_wdata, rdata_q;
    logic [BeW-1:0]        sel_be;

    arilla_rr_select #(
        .N    (NumManagers),
        .IdxW (OwnerW)
    ) u_select (
        .req        (m_req),
        .ptr        (ptr_q),
        .rr_mode    (RoundRobin != 0),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .win_vld    (win_vld)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int i = 0; i < NumManagers; i++) begin
            if (win_onehot[i]) begin
                sel_we    = m_we[i];
                sel_addr  = m_addr[i];
                sel_wdata = m_wdata[i];
                sel_be    = m_be[i];
            end
        end
    end

`ifdef ARILLA_BUS_ARBITER_TIMEOUT_EN
    localparam int WdW = $clog2(TimeoutCycles + 1);
    logic [WdW-1:0] wd_q;
    logic           timeout_fire, rerr_q;
`endif

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        resp_fire = 1'b0;
`ifdef ARILLA_BUS_ARBITER_TIMEOUT_EN
        timeout_fire = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (s_ready) begin
                    accept  = 1'b1;
                    state_d = s_we ? IDLE : RESP;
                end
            end
            RESP: begin
                if (s_rvalid) begin
                    resp_fire = 1'b1;
                    state_d   = IDLE;
                end
`ifdef ARILLA_BUS_ARBITER_TIMEOUT_EN
                else if (wd_q == WdW'(TimeoutCycles - 1)) begin
                    timeout_fire = 1'b1;
                    state_d      = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_req    = (state_q == ADDR);
    assign m_gnt    = accept ? (NumManagers'(1) << owner_q) : '0;
    assign m_rvalid = rvalid_q ? (NumManagers'(1) << owner_q) : '0;
    assign m_rdata  = rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            s_we     <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_be     <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= resp_fire;
            if (state_q == IDLE && win_vld) begin
                owner_q <= win_idx;
                s_we    <= sel_we;
                s_addr  <= sel_addr;
                s_wdata <= sel_wdata;
                s_be    <= sel_be;
            end
            // Pointer advances on every acceptance so RR never starves a waiting port.
            if (accept) begin
                ptr_q <= OwnerW'(next_rr_index(int'(owner_q), NumManagers));
            end
            if (resp_fire) begin
                rdata_q <= s_rdata;
            end
`ifdef ARILLA_BUS_ARBITER_TIMEOUT_EN
            if (timeout_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= '0;
            end
`endif
        end
    end

`ifdef ARILLA_BUS_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q   <= '0;
            rerr_q <= 1'b0;
        end else begin
            wd_q <= (state_q == RESP && state_d == RESP) ? wd_q + 1'b1 : '0;
            if (resp_fire) begin
                rerr_q <= 1'b0;
            end else if (timeout_fire) begin
                rerr_q <= 1'b1;
            end
        end
    end
    assign m_rerr = rerr_q;
`else
    assign m_rerr = 1'b0;
`endif

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// Directed and randomized checks of arilla_bus_arbiter (N=2), with a fixed-priority twin for arbitration order.
module tb_arilla_bus_arbiter;

    localparam int NM = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NM-1:0]   m_req = '0, m_we = '0;
    logic [NM-1:0][31:0] m_addr = '0, m_wdata = '0;
    logic [NM-1:0][3:0]  m_be = '0;
    logic            s_ready = 1'b0, s_rvalid = 1'b0;
    logic [31:0]     s_rdata = '0;

    logic [NM-1:0] m_gnt, m_rvalid, fp_gnt, fp_rvalid;
    logic [31:0]   m_rdata, fp_rdata, s_addr, s_wdata, fp_addr, fp_wdata;
    logic [3:0]    s_be, fp_be;
    logic          m_rerr, s_req, s_we, fp_rerr, fp_sreq, fp_we;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    arilla_bus_arbiter #(.NumManagers(NM), .RoundRobin(1), .TimeoutCycles(8)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_be(m_be), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rerr(m_rerr),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
        .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata));

    arilla_bus_arbiter #(.NumManagers(NM), .RoundRobin(0), .TimeoutCycles(8)) dut_fp (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_be(m_be), .m_gnt(fp_gnt), .m_rvalid(fp_rvalid), .m_rdata(fp_rdata), .m_rerr(fp_rerr),
        .s_req(fp_sreq), .s_we(fp_we), .s_addr(fp_addr), .s_wdata(fp_wdata), .s_be(fp_be),
        .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        m_req[i]   = 1'b1;
        m_we[i]    = we;
        m_addr[i]  = a;
        m_wdata[i] = d;
        m_be[i]    = be;
    endtask

    // Reference arbitration: first requester scanning upward from ptr, wrapping.
    function automatic int pick(input logic [NM-1:0] req, input int ptr);
        for (int k = 0; k < NM; k++) begin
            if (req[(ptr + k) % NM]) return (ptr + k) % NM;
        end
        return 0;
    endfunction

    // Random-phase model state
    logic          pv[NM];
    logic          pwe[NM];
    logic [31:0]   paddr[NM], pwdata[NM];
    logic [3:0]    pbe[NM];
    logic [31:0]   mem[16];
    int            phase, owner_m, ptr_m, lat, rd_idx;
    logic          rv_due, rv_drv;
    logic [31:0]   exp_rdata;
    logic [NM-1:0] req_drv;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NM-1:0] got[$];
        logic [NM-1:0] fpgot[$];
        logic [NM-1:0] fp_after;
        logic [NM-1:0] exp_pat[4];
        int            cnt;

        // ---- reset state
        repeat (2) tick();
        look();
        chk("rst_sreq", s_req, 0);
        chk("rst_gnt", m_gnt, 0);
        chk("rst_rvalid", m_rvalid, 0);
        chk("rst_rdata", m_rdata, 0);
        chk("rst_rerr", m_rerr, 0);
        chk("rst_saddr", s_addr, 0);
        tick();
        rst = 1'b0;

        // ---- 1: single write from m0
        tick();
        set_req(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        s_ready = 1'b1;
        look();
        chk("t1_idle_sreq", s_req, 0);
        chk("t1_idle_gnt", m_gnt, 0);
        tick();
        look();
        chk("t1_sreq", s_req, 1);
        chk("t1_swe", s_we, 1);
        chk("t1_saddr", s_addr, 32'h100);
        chk("t1_swdata", s_wdata, 32'hDEADBEEF);
        chk("t1_sbe", s_be, 4'hF);
        chk("t1_gnt", m_gnt, 2'b01);
        tick();
        m_req = '0;
        look();
        chk("t1_after_sreq", s_req, 0);
        chk("t1_after_gnt", m_gnt, 0);
        chk("t1_no_rvalid", m_rvalid, 0);

        // ---- 2: read from m1, one-cycle subordinate
        tick();
        set_req(1, 1'b0, 32'h40, 32'h0, 4'hF);
        look();
        chk("t2_a_rvalid", m_rvalid, 0);
        tick();
        look();
        chk("t2_saddr", s_addr, 32'h40);
        chk("t2_swe", s_we, 0);
        chk("t2_gnt", m_gnt, 2'b10);
        tick();
        m_req = '0;
        s_rvalid = 1'b1;
        s_rdata = 32'h12345678;
        look();
        chk("t2_resp_sreq", s_req, 0);
        chk("t2_resp_rvalid", m_rvalid, 0);
        tick();
        s_rvalid = 1'b0;
        s_rdata = '0;
        look();
        chk("t2_rvalid", m_rvalid, 2'b10);
        chk("t2_rdata", m_rdata, 32'h12345678);
        chk("t2_rerr", m_rerr, 0);
        tick();
        look();
        chk("t2_rvalid_pulse", m_rvalid, 0);

        // ---- 3: contention, RR alternates, fixed priority sticks to m0
        tick();
        set_req(0, 1'b1, 32'h200, 32'h11111111, 4'hF);
        set_req(1, 1'b1, 32'h300, 32'h22222222, 4'hF);
        for (int c = 0; c < 30 && got.size() < 4; c++) begin
            look();
            if (m_gnt != 0) begin
                got.push_back(m_gnt);
                chk("t3_addr_of_winner", s_addr, (m_gnt == 2'b01) ? 32'h200 : 32'h300);
            end
            if (fp_gnt != 0) fpgot.push_back(fp_gnt);
            tick();
        end
        exp_pat[0] = 2'b01; exp_pat[1] = 2'b10; exp_pat[2] = 2'b01; exp_pat[3] = 2'b10;
        chk("t3_rr_count", got.size(), 4);
        chk("t3_fp_count", fpgot.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3_rr_order%0d", k), (got.size() > k) ? got[k] : 2'b00, exp_pat[k]);
            chk($sformatf("t3_fp_order%0d", k), (fpgot.size() > k) ? fpgot[k] : 2'b00, 2'b01);
        end
        m_req[0] = 1'b0;
        fp_after = '0;
        for (int c = 0; c < 10 && fp_after == 0; c++) begin
            look();
            if (fp_gnt != 0) fp_after = fp_gnt;
            tick();
        end
        chk("t3_fp_after_drop", fp_after, 2'b10);
        m_req = '0;
        repeat (3) tick();

        // ---- 4: backpressure for 5 cycles
        s_ready = 1'b0;
        set_req(0, 1'b1, 32'h80, 32'hA5A50F0F, 4'h3);
        look();
        for (int k = 0; k < 5; k++) begin
            tick();
            look();
            chk($sformatf("t4_sreq%0d", k), s_req, 1);
            chk($sformatf("t4_saddr%0d", k), s_addr, 32'h80);
            chk($sformatf("t4_swdata%0d", k), s_wdata, 32'hA5A50F0F);
            chk($sformatf("t4_sbe%0d", k), s_be, 4'h3);
            chk($sformatf("t4_nogrant%0d", k), m_gnt, 0);
        end
        tick();
        s_ready = 1'b1;
        look();
        chk("t4_grant6", m_gnt, 2'b01);
        tick();
        m_req = '0;

        // ---- 5: reset while waiting for read data
        set_req(0, 1'b0, 32'h44, 32'h0, 4'hF);
        look();
        tick();
        look();
        chk("t5_gnt", m_gnt, 2'b01);
        tick();
        m_req = '0;
        look();
        chk("t5_resp_rvalid", m_rvalid, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_sreq", s_req, 0);
        chk("t5_async_gnt", m_gnt, 0);
        chk("t5_async_rvalid", m_rvalid, 0);
        chk("t5_async_rdata", m_rdata, 0);
        chk("t5_async_saddr", s_addr, 0);
        chk("t5_async_sbe", s_be, 0);
        tick();
        s_rvalid = 1'b1;
        s_rdata = 32'h00000BAD;
        tick();
        rst = 1'b0;
        look();
        chk("t5_post_rvalid0", m_rvalid, 0);
        tick();
        s_rvalid = 1'b0;
        look();
        chk("t5_post_rvalid1", m_rvalid, 0);
        tick();
        look();
        chk("t5_post_rvalid2", m_rvalid, 0);
        tick();
        set_req(1, 1'b0, 32'h48, 32'h0, 4'hF);
        look();
        tick();
        look();
        chk("t5_next_gnt", m_gnt, 2'b10);
        tick();
        m_req = '0;
        s_rvalid = 1'b1;
        s_rdata = 32'hCAFEF00D;
        look();
        tick();
        s_rvalid = 1'b0;
        look();
        chk("t5_next_rvalid", m_rvalid, 2'b10);
        chk("t5_next_rdata", m_rdata, 32'hCAFEF00D);

        // ---- 6: read that never gets data
        tick();
        set_req(0, 1'b0, 32'h4C, 32'h0, 4'hF);
        look();
        tick();
        look();
        chk("t6_gnt", m_gnt, 2'b01);
        tick();
        m_req = '0;
`ifdef ARILLA_BUS_ARBITER_TIMEOUT_EN
        cnt = 0;
        for (int r = 0; r < 8; r++) begin
            look();
            if (m_rvalid != 0) cnt++;
            tick();
        end
        look();
        chk("t6_early_rvalid", cnt, 0);
        chk("t6_to_rvalid", m_rvalid, 2'b01);
        chk("t6_to_rerr", m_rerr, 1);
        chk("t6_to_rdata", m_rdata, 0);
        tick();
        s_rvalid = 1'b1;
        s_rdata = 32'h77777777;
        look();
        chk("t6_late_ignored0", m_rvalid, 0);
        tick();
        s_rvalid = 1'b0;
        look();
        chk("t6_late_ignored1", m_rvalid, 0);
`else
        cnt = 0;
        for (int r = 0; r < 100; r++) begin
            look();
            if (m_rvalid != 0) cnt++;
            tick();
        end
        look();
        chk("t6_no_timeout_rvalid", cnt, 0);
        chk("t6_still_waiting_sreq", s_req, 0);
        chk("t6_rerr_tied", m_rerr, 0);
        chk("t6_still_waiting_gnt", m_gnt, 0);
`endif

        // ---- randomized traffic against a transaction-level model
        tick();
        rst = 1'b1;
        m_req = '0;
        s_rvalid = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NM; i++) pv[i] = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        phase = 0; ptr_m = 0; owner_m = 0; lat = 0; rd_idx = 0;
        rv_due = 1'b0; exp_rdata = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            tick();
            for (int i = 0; i < NM; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    pv[i]     = 1'b1;
                    pwe[i]    = 1'($urandom_range(0, 1));
                    paddr[i]  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                    pwdata[i] = $urandom;
                    pbe[i]    = 4'($urandom_range(1, 15));
                end
                m_req[i]   = pv[i];
                m_we[i]    = pv[i] ? pwe[i] : 1'b0;
                m_addr[i]  = pv[i] ? paddr[i] : 32'h0;
                m_wdata[i] = pv[i] ? pwdata[i] : 32'h0;
                m_be[i]    = pv[i] ? pbe[i] : 4'h0;
            end
            req_drv = m_req;
            s_ready = ($urandom_range(0, 3) != 0);
            if (phase == 2) begin
                rv_drv = (lat == 0);
                if (lat > 0) lat--;
                s_rdata = rv_drv ? mem[rd_idx] : $urandom;
            end else begin
                rv_drv = ($urandom_range(0, 3) == 0);
                s_rdata = $urandom;
            end
            s_rvalid = rv_drv;

            look();
            chk("r_sreq", s_req, (phase == 1));
            if (phase == 1) begin
                chk("r_swe", s_we, pwe[owner_m]);
                chk("r_saddr", s_addr, paddr[owner_m]);
                chk("r_swdata", s_wdata, pwdata[owner_m]);
                chk("r_sbe", s_be, pbe[owner_m]);
            end
            chk("r_gnt", m_gnt, (phase == 1 && s_ready) ? (2'b01 << owner_m) : 2'b00);
            chk("r_rvalid", m_rvalid, rv_due ? (2'b01 << owner_m) : 2'b00);
            if (rv_due) begin
                chk("r_rdata", m_rdata, exp_rdata);
                chk("r_rerr", m_rerr, 0);
            end

            rv_due = 1'b0;
            case (phase)
                0: if (req_drv != 0) begin
                    owner_m = pick(req_drv, ptr_m);
                    phase = 1;
                end
                1: if (s_ready) begin
                    ptr_m = (owner_m + 1) % NM;
                    pv[owner_m] = 1'b0;
                    if (pwe[owner_m]) begin
                        for (int b = 0; b < 4; b++)
                            if (pbe[owner_m][b]) mem[paddr[owner_m][5:2]][8*b +: 8] = pwdata[owner_m][8*b +: 8];
                        phase = 0;
                    end else begin
                        rd_idx = int'(paddr[owner_m][5:2]);
                        lat = $urandom_range(0, 2);
                        phase = 2;
                    end
                end
                default: if (rv_drv) begin
                    exp_rdata = mem[rd_idx];
                    rv_due = 1'b1;
                    phase = 0;
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
